// File: rtl/rv32_boot_ctrl_pkg.sv
// Shared definitions for the rv32 boot/run sequencer: controller state
// encoding, completion status codes and the instruction constants the core
// decoder also relies on (NOP and EBREAK).
package rv32_boot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'b00,
    STAT_HALT    = 2'b01,
    STAT_TIMEOUT = 2'b10,
    STAT_RANGE   = 2'b11
  } status_e;

  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;
  localparam logic [31:0] INSTR_NOP    = 32'h00000013;

  // A byte fetch address is out of range when any bit above the RAM word
  // address (plus the two byte-offset bits) is set.
  function automatic logic lc_out_of_range(input logic [15:0] lc, input int addr_w);
    return (32'(lc) >> (addr_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/rv32_boot_ctrl_run_timer.sv
// Run-cycle timer: counts cycles while enabled, cleared on demand, and flags
// the cycle on which the count reaches MAX_RUN-1 (the last allowed RUN cycle).
//  clk, rst_n  clock / async active-low reset
//  clr         synchronous clear of the count
//  en          count this cycle (saturates at all-ones)
//  expired     count == MAX_RUN-1; never asserted when MAX_RUN == 0
module rv32_boot_ctrl_run_timer
  import rv32_boot_ctrl_pkg::*;
#(
  parameter int MAX_RUN = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int RW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
  localparam logic [RW-1:0] LAST = (MAX_RUN > 0) ? RW'(MAX_RUN - 1) : '0;

  logic [RW-1:0] rcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rcnt <= '0;
    else if (clr)               rcnt <= '0;
    else if (en && rcnt != '1)  rcnt <= rcnt + 1'b1;
  end

  assign expired = (MAX_RUN != 0) && (rcnt == LAST);

endmodule

// File: rtl/rv32_boot_ctrl.sv
// Boot/run sequencer for cpu_rv32. Shares the instruction RAM port between a
// host loader and the core fetch path, holds the core in reset while loading,
// releases it, pulses start, then watches fetch for halt/timeout/range errors.
//  load_req/load_len  start a load of load_len words at address 0 (0 = ignored)
//  run_req            rerun the loaded program;  abort: back to IDLE (level)
//  wr_valid/wr_ready/wr_data   host word stream
//  cpu_rst_n/cpu_start/cpu_lc/cpu_instr   core control and fetch
//  mem_addr/mem_we/mem_wdata/mem_rdata    RAM port (combinational read)
//  busy (LOAD/START/RUN), done (DONE), status (valid while done)
module rv32_boot_ctrl
  import rv32_boot_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          START_DLY  = 4,
  parameter int          MAX_RUN    = 100,
  parameter logic [31:0] HALT_INSTR = INSTR_EBREAK,
  parameter logic [31:0] NOP_INSTR  = INSTR_NOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              cpu_start,
  input  logic [15:0]       cpu_lc,
  output logic [31:0]       cpu_instr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  localparam logic [7:0] DLY_LAST = 8'(START_DLY - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, wcnt_q, wcnt_d, len_m1;
  logic              loaded_q, loaded_d;
  logic [7:0]        dcnt_q, dcnt_d;
  status_e           stat_hit;
  logic              timer_clr, timer_en, timer_exp;
  logic [ADDR_W-1:0] lc_word;

  assign len_m1  = len_q - 1'b1;
  assign lc_word = cpu_lc[ADDR_W+1:2];

  rv32_boot_ctrl_run_timer #(.MAX_RUN(MAX_RUN)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_exp)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    loaded_d  = loaded_q;
    dcnt_d    = dcnt_q;
    stat_hit  = STAT_NONE;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = wcnt_q[ADDR_W-1:0];
    mem_wdata = wr_data;
    cpu_instr = NOP_INSTR;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_req && load_len != '0) begin
          state_d  = ST_LOAD;
          len_d    = load_len;
          wcnt_d   = '0;
          loaded_d = 1'b0;
        end else if (run_req && loaded_q) begin
          state_d = ST_START;
          dcnt_d  = '0;
        end
      end
      ST_LOAD: begin
        wr_ready = 1'b1;
        mem_we   = wr_valid;
        if (wr_valid) begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == len_m1) begin
            state_d  = ST_START;
            loaded_d = 1'b1;
            dcnt_d   = '0;
          end
        end
      end
      ST_START: begin
        timer_clr = 1'b1;
        if (dcnt_q == DLY_LAST) state_d = ST_RUN;
        else                    dcnt_d  = dcnt_q + 8'd1;
      end
      ST_RUN: begin
        timer_en  = 1'b1;
        mem_addr  = lc_word;
        cpu_instr = mem_rdata;
        // Range error beats halt beats timeout; the core never sees the
        // EBREAK or a word fetched from a bogus address.
        if (lc_out_of_range(cpu_lc, ADDR_W)) begin
          cpu_instr = NOP_INSTR;
          stat_hit  = STAT_RANGE;
          state_d   = ST_DONE;
        end else if (mem_rdata == HALT_INSTR) begin
          cpu_instr = NOP_INSTR;
          stat_hit  = STAT_HALT;
          state_d   = ST_DONE;
        end else if (timer_exp) begin
          stat_hit  = STAT_TIMEOUT;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Registered outputs are decoded from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      wcnt_q    <= '0;
      loaded_q  <= 1'b0;
      dcnt_q    <= '0;
      cpu_rst_n <= 1'b0;
      cpu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= STAT_NONE;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      loaded_q  <= loaded_d;
      dcnt_q    <= dcnt_d;
      cpu_rst_n <= (state_d == ST_START) || (state_d == ST_RUN);
      cpu_start <= (state_d == ST_START) && (dcnt_d == DLY_LAST);
      busy      <= (state_d == ST_LOAD) || (state_d == ST_START) || (state_d == ST_RUN);
      done      <= (state_d == ST_DONE);
      if (state_d != ST_DONE)    status <= STAT_NONE;
      else if (state_q == ST_RUN) status <= stat_hit;
    end
  end

endmodule

// File: tb/tb_rv32_boot_ctrl.sv
module tb_rv32_boot_ctrl;
  localparam int ADDR_W = 10;
  localparam int START_DLY = 4;
  localparam int MAX_RUN = 100;
  localparam logic [31:0] HALT = 32'h00100073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic clk = 1'b0, rst_n = 1'b0;
  logic load_req = 1'b0, run_req = 1'b0, abort = 1'b0;
  logic [ADDR_W:0] load_len = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic cpu_rst_n, cpu_start;
  logic [15:0] cpu_lc = '0;
  logic [31:0] cpu_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic busy, done;
  logic [1:0] status;

  logic [31:0] ram [0:1023];
  logic [31:0] model_mem [0:1023];
  logic [31:0] prog [0:15];
  logic [15:0] lcs [0:299];
  int wr_log[$];
  int n_vec = 0, n_bad = 0;

  typedef struct {
    int len; int halt; int jcyc; logic [15:0] jlc; bit tog;
    logic [1:0] est; int eend;
  } vec_t;
  vec_t tbl [7];

  rv32_boot_ctrl #(.ADDR_W(ADDR_W), .START_DLY(START_DLY), .MAX_RUN(MAX_RUN),
                   .HALT_INSTR(HALT), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .run_req(run_req), .abort(abort),
    .load_len(load_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .cpu_rst_n(cpu_rst_n), .cpu_start(cpu_start), .cpu_lc(cpu_lc), .cpu_instr(cpu_instr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .status(status));

  always #5 clk = ~clk;

  // Instruction RAM environment with a write log.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) begin
    ram[mem_addr] = mem_wdata;
    wr_log.push_back(int'(mem_addr));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: what the core should see for a fetch address.
  function automatic logic [31:0] model_instr(input logic [15:0] lc);
    logic [31:0] w;
    if ((lc >> (ADDR_W + 2)) != 0) return NOP;
    w = model_mem[lc[ADDR_W+1:2]];
    return (w == HALT) ? NOP : w;
  endfunction

  // Reference: RUN cycle at which the run ends, and its status.
  function automatic int model_end(output logic [1:0] st);
    for (int i = 0; i < MAX_RUN; i++) begin
      if ((lcs[i] >> (ADDR_W + 2)) != 0) begin st = 2'd3; return i; end
      if (model_mem[lcs[i][ADDR_W+1:2]] == HALT) begin st = 2'd1; return i; end
    end
    st = 2'd2;
    return MAX_RUN - 1;
  endfunction

  task automatic req_load(input int n);
    load_req = 1'b1; load_len = (ADDR_W+1)'(n);
    tick();
    load_req = 1'b0;
  endtask

  task automatic feed(input int n, input bit tog, input int stop_after);
    int k = 0, cyc = 0;
    int target = (stop_after >= 0) ? stop_after : n;
    bit acc;
    wr_log.delete();
    while (k < target && cyc < 200) begin
      wr_valid = tog ? (cyc % 2 == 1) : 1'b1;
      wr_data = prog[k];
      @(negedge clk);
      acc = wr_valid && wr_ready;
      tick();
      if (acc) begin model_mem[k] = prog[k]; k++; end
      cyc++;
    end
    wr_valid = 1'b0;
    if (k != target) chk("load_timeout", k, target);
    chk("wr_count", wr_log.size(), target);
    for (int j = 0; j < wr_log.size() && j < target; j++) chk("wr_addr", wr_log[j], j);
  endtask

  task automatic wait_start();
    int cnt = 0;
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk("rst_release", cpu_rst_n, 1);
      if (cpu_start) seen = 1'b1;
      else tick();
    end
    chk("start_dly", cnt, START_DLY);
    tick();
  endtask

  task automatic do_run(output int e, output logic [1:0] st);
    e = -1; st = 2'd0;
    for (int i = 0; i < 300; i++) begin
      cpu_lc = lcs[i];
      @(negedge clk);
      if (done) begin
        e = i - 1; st = status;
        chk("rst_on_done", cpu_rst_n, 0);
        break;
      end
      if (i == 0) chk("start_pulse", cpu_start, 0);
      chk("instr", cpu_instr, model_instr(lcs[i]));
      tick();
    end
    tick();
  endtask

  initial begin
    int e, exp_e, len;
    logic [1:0] st, exp_st;
    bit tog;

    //           len halt jcyc jlc       tog est eend
    tbl[0] = '{3,  2,  -1, 16'h0000, 1'b0, 2'd1, 2};
    tbl[1] = '{5,  4,  -1, 16'h0000, 1'b1, 2'd1, 4};
    tbl[2] = '{3,  -1, -1, 16'h0000, 1'b0, 2'd2, 99};
    tbl[3] = '{4,  -1, 1,  16'h1000, 1'b0, 2'd3, 1};
    tbl[4] = '{4,  3,  3,  16'h1000, 1'b1, 2'd3, 3};
    tbl[5] = '{2,  1,  1,  16'h0FFC, 1'b0, 2'd1, 3};
    tbl[6] = '{3,  1,  0,  16'h0007, 1'b0, 2'd1, 0};
    for (int i = 0; i < 1024; i++) begin ram[i] = '0; model_mem[i] = '0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_cpu_start", cpu_start, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_instr", cpu_instr, NOP);
    rst_n = 1'b1;
    tick();

    // Table-driven programs.
    foreach (tbl[t]) begin
      for (int k = 0; k < tbl[t].len; k++)
        prog[k] = (k == tbl[t].halt) ? HALT : {12'(k + 1), 5'd0, 3'b000, 5'd1, 7'h13};
      for (int i = 0; i < 300; i++)
        lcs[i] = (i == tbl[t].jcyc) ? tbl[t].jlc : 16'(4 * (i % tbl[t].len));
      req_load(tbl[t].len);
      feed(tbl[t].len, tbl[t].tog, -1);
      wait_start();
      do_run(e, st);
      chk($sformatf("t%0d_end", t), e, tbl[t].eend);
      chk($sformatf("t%0d_status", t), st, tbl[t].est);
    end

    // Abort mid-load: loaded stays clear, run_req ignored.
    for (int k = 0; k < 5; k++) prog[k] = {12'(k + 7), 5'd0, 3'b000, 5'd2, 7'h13};
    req_load(5);
    feed(5, 1'b0, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    chk("abort_ld_busy", busy, 0);
    chk("abort_ld_rst", cpu_rst_n, 0);
    chk("abort_ld_rdy", wr_ready, 0);
    tick();
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("run_ignored_busy", busy, 0);
    chk("run_ignored_rst", cpu_rst_n, 0);
    tick();

    // Abort mid-run.
    req_load(3);
    feed(3, 1'b0, -1);
    wait_start();
    cpu_lc = 16'h0;
    repeat (5) tick();
    @(negedge clk);
    chk("run_rst_high", cpu_rst_n, 1);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    chk("abort_run_rst", cpu_rst_n, 0);
    chk("abort_run_busy", busy, 0);
    chk("abort_run_done", done, 0);
    tick();

    // Program still loaded: rerun, jump out of range at once.
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_start();
    lcs[0] = 16'h1000;
    do_run(e, st);
    chk("range_end", e, 0);
    chk("range_status", st, 2'd3);

    // In DONE: zero-length load is ignored.
    load_req = 1'b1; load_len = '0; tick(); load_req = 1'b0;
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_status", status, 2'd3);
    tick();

    // In DONE: load_req beats run_req.
    prog[0] = 32'h00500093; prog[1] = HALT;
    load_req = 1'b1; run_req = 1'b1; load_len = 11'd2;
    tick();
    load_req = 1'b0; run_req = 1'b0;
    @(negedge clk);
    chk("ld_wins_rdy", wr_ready, 1);
    chk("ld_wins_status", status, 0);
    chk("ld_wins_done", done, 0);
    tick();
    feed(2, 1'b0, -1);
    wait_start();
    for (int i = 0; i < 300; i++) lcs[i] = (i == 0) ? 16'h0 : 16'h4;
    do_run(e, st);
    chk("ld2_end", e, 1);
    chk("ld2_status", st, 2'd1);
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_start();
    do_run(e, st);
    chk("rerun_end", e, 1);
    chk("rerun_status", st, 2'd1);

    // Randomized programs and fetch streams against the reference model.
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(1, 12);
      tog = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++)
        prog[k] = ($urandom_range(0, 5) == 0) ? HALT : $urandom();
      for (int i = 0; i < 300; i++)
        lcs[i] = ($urandom_range(0, 24) == 0) ? 16'($urandom())
               : 16'(4 * $urandom_range(0, len - 1) + $urandom_range(0, 3));
      req_load(len);
      feed(len, tog, -1);
      exp_e = model_end(exp_st);
      wait_start();
      do_run(e, st);
      chk($sformatf("rnd%0d_end", it), e, exp_e);
      chk($sformatf("rnd%0d_status", it), st, exp_st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
